// File: rtl/memory_bus_arbiter_pkg.sv
// Shared memory-bus types: request type, packet layout and arbiter FSM states.
package memory_bus_arbiter_pkg;

  localparam int MAX_SOURCES = 8;
  localparam int MAX_SRC_W   = $clog2(MAX_SOURCES);

  typedef enum logic {
    bus_read_data  = 1'b0,
    bus_write_data = 1'b1
  } bus_packet_type_t;

  typedef logic [63:0] bus_packet_payload_t;

  // The source field is sized for the largest legal configuration.
  typedef struct packed {
    bus_packet_type_t     pkt_type;
    logic [MAX_SRC_W-1:0] source;
    logic [63:0]          address;
    bus_packet_payload_t  payload;
  } BusPacket;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_SEND     = 2'd1,
    ARB_WAIT_RSP = 2'd2
  } arb_state_t;

  function automatic int next_src(input int idx, input int num_sources);
    return (idx + 1 >= num_sources) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_if.sv
// Requester + DRAM channel bundle; master is the arbiter's view, slave is the requesters/DRAM view.
interface memory_bus_arbiter_if #(
  parameter int NUM_SOURCES = 2,
  parameter int SRC_W       = $clog2(NUM_SOURCES)
);
  import memory_bus_arbiter_pkg::*;

  logic [NUM_SOURCES-1:0] req_valid;
  logic [NUM_SOURCES-1:0] req_ready;
  bus_packet_type_t       req_type    [NUM_SOURCES];
  logic [63:0]            req_address [NUM_SOURCES];
  bus_packet_payload_t    req_payload [NUM_SOURCES];

  logic                   dram_req_valid;
  logic                   dram_req_ready;
  BusPacket               dram_req_pkt;

  logic                   dram_rsp_valid;
  bus_packet_payload_t    dram_rsp_payload;
  logic [SRC_W-1:0]       dram_rsp_source;

  logic [NUM_SOURCES-1:0] rsp_valid;
  bus_packet_payload_t    rsp_payload;
  logic                   proto_error;

  modport master (
    input  req_valid, req_type, req_address, req_payload,
    input  dram_req_ready, dram_rsp_valid, dram_rsp_payload, dram_rsp_source,
    output req_ready, dram_req_valid, dram_req_pkt, rsp_valid, rsp_payload, proto_error
  );

  modport slave (
    output req_valid, req_type, req_address, req_payload,
    output dram_req_ready, dram_rsp_valid, dram_rsp_payload, dram_rsp_source,
    input  req_ready, dram_req_valid, dram_req_pkt, rsp_valid, rsp_payload, proto_error
  );

endinterface

// File: rtl/memory_bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first set bit of req scanning upward from ptr, with wraparound.
module rr_picker #(
  parameter int WIDTH = 2,
  parameter int PTR_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] winner,
  output logic             found
);

  int idx;

  always_comb begin
    // NOTE: every signal written in always_comb gets a default first; a path that skips it would infer a latch.
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < WIDTH; i++) begin
      idx = (int'(ptr) + i) % WIDTH;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter merging NUM_SOURCES requesters onto one DRAM channel, one request in flight.
// Optional grant/stall counters are built when MEMORY_BUS_ARBITER_STATS_EN is defined.
module memory_bus_arbiter
  import memory_bus_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = 2,
  parameter int SRC_W       = $clog2(NUM_SOURCES)
) (
  input  logic                 clk,
  input  logic                 reset,
  memory_bus_arbiter_if.master bus
`ifdef MEMORY_BUS_ARBITER_STATS_EN
  ,
  output logic [31:0]          grant_count [NUM_SOURCES],
  output logic [31:0]          stall_count
`endif
);

  arb_state_t             state_q, state_d;
  logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]       pending_src_q, pending_src_d;
  BusPacket               pkt_q, pkt_d;
  logic [NUM_SOURCES-1:0] rsp_valid_q, rsp_valid_d;
  bus_packet_payload_t    rsp_payload_q, rsp_payload_d;
  logic                   proto_error_q, proto_error_d;

  logic [SRC_W-1:0]       winner;
  logic                   found;
  logic                   grant;
  logic                   rsp_match;
  logic [NUM_SOURCES-1:0] req_ready;

  rr_picker #(.WIDTH(NUM_SOURCES), .PTR_W(SRC_W)) u_rr_picker (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_q),
    .winner (winner),
    .found  (found)
  );

  // Gating with reset keeps req_ready low while reset is held, since it is combinational.
  assign grant     = (state_q == ARB_IDLE) && found && !reset;
  assign rsp_match = (state_q == ARB_WAIT_RSP) && (bus.dram_rsp_source == pending_src_q);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    pending_src_d = pending_src_q;
    pkt_d         = pkt_q;
    rsp_valid_d   = '0;
    rsp_payload_d = rsp_payload_q;
    proto_error_d = proto_error_q;
    req_ready     = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          req_ready[winner] = 1'b1;
          pkt_d.pkt_type    = bus.req_type[winner];
          pkt_d.source      = MAX_SRC_W'(winner);
          pkt_d.address     = bus.req_address[winner];
          pkt_d.payload     = bus.req_payload[winner];
          rr_ptr_d          = SRC_W'(next_src(int'(winner), NUM_SOURCES));
          state_d           = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (bus.dram_req_ready) begin
          if (pkt_q.pkt_type == bus_read_data) begin
            pending_src_d = SRC_W'(pkt_q.source);
            state_d       = ARB_WAIT_RSP;
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      ARB_WAIT_RSP: begin
        if (bus.dram_rsp_valid && rsp_match) begin
          rsp_valid_d[pending_src_q] = 1'b1;
          rsp_payload_d              = bus.dram_rsp_payload;
          state_d                    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // A response in any state other than a matching wait is dropped and flagged.
    if (bus.dram_rsp_valid && !rsp_match) begin
      proto_error_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      rr_ptr_q      <= '0;
      pending_src_q <= '0;
      pkt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_payload_q <= '0;
      proto_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      pending_src_q <= pending_src_d;
      pkt_q         <= pkt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_payload_q <= rsp_payload_d;
      proto_error_q <= proto_error_d;
    end
  end

  assign bus.req_ready      = req_ready;
  assign bus.dram_req_valid = (state_q == ARB_SEND);
  assign bus.dram_req_pkt   = pkt_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_payload    = rsp_payload_q;
  assign bus.proto_error    = proto_error_q;

`ifdef MEMORY_BUS_ARBITER_STATS_EN
  logic [31:0] grant_count_q [NUM_SOURCES];
  logic [31:0] grant_count_d [NUM_SOURCES];
  logic [31:0] stall_count_q, stall_count_d;

  // Counters saturate rather than wrap.
  always_comb begin
    grant_count_d = grant_count_q;
    stall_count_d = stall_count_q;
    if (grant && (grant_count_q[winner] != 32'hFFFF_FFFF)) begin
      grant_count_d[winner] = grant_count_q[winner] + 32'd1;
    end
    if ((|bus.req_valid) && !grant && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        grant_count_q[i] <= '0;
      end
      stall_count_q <= '0;
    end else begin
      grant_count_q <= grant_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign grant_count = grant_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/memory_bus_arbiter.md
# memory_bus_arbiter

Round-robin arbiter that sits directly upstream of the DRAM model. It merges memory requests from NUM_SOURCES requesters (instruction fetch, load/store, …) onto the single DRAM request channel and stamps each request with the requester index. It routes each DRAM read response back to the requester that issued it. At most one request is in flight at a time, which matches the DRAM's one-packet-at-a-time service.

## Interface
- NUM_SOURCES, default 2: number of requesters; legal range 2..8.
- SRC_W, default $clog2(NUM_SOURCES): width of the source field.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_SOURCES  per-requester request valid.
- req_ready  out  NUM_SOURCES  per-requester accept; one-hot or zero.
- req_type  in  NUM_SOURCES×bus_packet_type_t  bus_read_data or bus_write_data.
- req_address  in  NUM_SOURCES×64  byte address.
- req_payload  in  NUM_SOURCES×64  write data; ignored for reads.
- dram_req_valid  out  1  request to DRAM valid.
- dram_req_ready  in  1  DRAM accepts the request.
- dram_req_pkt  out  BusPacket  type, address, payload; source = granted index.
- dram_rsp_valid  in  1  one-cycle read response pulse from DRAM.
- dram_rsp_payload  in  64  read data.
- dram_rsp_source  in  SRC_W  source carried by the response.
- rsp_valid  out  NUM_SOURCES  one-cycle, one-hot response pulse to the requester.
- rsp_payload  out  64  read data, registered, shared by all requesters.
- proto_error  out  1  sticky; set on any unexpected response.

## Operation
- The FSM has three states.
  - ARB_IDLE: if any req_valid is set, the winner is the first set bit scanning from rr_ptr upward with wraparound. req_ready[winner]=1 for this cycle. The request is latched into dram_req_pkt with source=winner. rr_ptr becomes (winner+1) mod NUM_SOURCES. Next state is ARB_SEND.
  - ARB_SEND: dram_req_valid=1. On dram_req_ready: a write returns to ARB_IDLE; a read records pending_src=source and goes to ARB_WAIT_RSP.
  - ARB_WAIT_RSP: on dram_rsp_valid with dram_rsp_source==pending_src, pulse rsp_valid[pending_src] and load rsp_payload, then go to ARB_IDLE.
- Response handling edge cases:
  - A dram_rsp_valid whose source mismatches pending_src, or that arrives in any other state, is dropped and sets proto_error.
  - In the mismatch case the FSM stays in ARB_WAIT_RSP.
- dram_req_pkt holds stable from the grant until the DRAM handshake completes.
- req_ready is never asserted outside ARB_IDLE, so requesters stall while a request is in flight.
- Reset values:
  - State ARB_IDLE, rr_ptr=0, pending_src=0.
  - All req_ready=0, dram_req_valid=0, rsp_valid=0, rsp_payload=0, dram_req_pkt=0, proto_error=0.
- Reset mid-operation:
  - The in-flight request is abandoned.
  - A DRAM response arriving after reset is an unexpected response and sets proto_error.

## Timing
- Grant at cycle T (combinational req_ready in ARB_IDLE); dram_req_valid from T+1.
- Write: the earliest next grant is at the cycle after the DRAM handshake.
- Read: rsp_valid is asserted one cycle after dram_rsp_valid (registered); the next grant is possible in that same cycle.
- With all requesters continuously valid, grants rotate 0,1,…,N-1,0. No requester waits more than NUM_SOURCES grants.
- If DRAM asserts dram_rsp_valid in the same cycle as dram_req_ready, the response is treated as unexpected. DRAM always takes at least one cycle.

## Configuration
- MEMORY_BUS_ARBITER_STATS_EN
  - Defined: per-source 32-bit grant counters and a 32-bit stall-cycle counter are present. The stall counter increments on each cycle where any req_valid is set without a grant. All counters are readable through output grant_count[NUM_SOURCES] and stall_count. They reset to 0 and saturate at 0xFFFF_FFFF.
  - Undefined: the counters and their ports are absent; all other behaviour is identical.

## Structure
- bus_packet_type_t, BusPacket, bus_packet_payload_t and the arbiter state enum belong in the shared memory-bus package. MAX_SOURCES=8 also goes there.
- Sub-module rr_picker: combinational first-set-bit-from-pointer selector. It is parameterised by width and returns the winner index plus a found flag.

## Test plan
- Single read: source 1 reads 0x100; DRAM responds with 0xDEADBEEF_00000001, source 1. Required: rsp_valid=0b10 one cycle after the response, with rsp_payload=0xDEADBEEF_00000001.
- Fairness: both sources hold writes continuously and DRAM is always ready. Required: dram_req_pkt.source sequence 0,1,0,1 from reset.
- Backpressure: hold dram_req_ready=0 for 5 cycles. Required: dram_req_pkt stays constant, req_ready=0, and the grant completes on the cycle dram_req_ready rises.
- Bad source: a read is pending for source 0 and a response arrives with source 1. Required: no rsp_valid, proto_error=1, and the FSM still accepts a later response with source 0.
- Async reset during ARB_WAIT_RSP: all outputs return to 0 without a clock edge, and the next grant goes to source 0.
- With STATS_EN: 3 grants to source 0 and 2 blocked cycles. Required: grant_count[0]=3 and stall_count=2.
